// File: rtl/rv32e_pkg.sv
// rv32e_pkg: shared FSM states, requester IDs and strobe width for the memory arbiter.
// Revision: 1.0
`default_nettype none

package rv32e_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;
  localparam int   STRB_W = 4;

endpackage

`default_nettype wire

// File: rtl/rv32e_arb_sel.sv
// rv32e_arb_sel: data-over-fetch winner selection with a saturating streak guard for fetch.
// Revision: 1.0
`default_nettype none

module rv32e_arb_sel
  import rv32e_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic arb,
  output logic win_id,
  output logic win_valid
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] streak;
  logic       fetch_turn;

  always_comb begin
    fetch_turn = if_req && ((streak == STREAK_MAX) || !d_req);
    win_valid  = if_req || d_req;
    win_id     = fetch_turn ? REQ_IF : REQ_D;
  end

  // Streak only counts data wins that actually made fetch wait.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak <= 4'd0;
    end else if (arb && win_valid) begin
      if (fetch_turn || !if_req) begin
        streak <= 4'd0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32e_mem_arb.sv
// rv32e_mem_arb: shares one single-ported synchronous memory between fetch and load/store.
// Revision: 1.0
`default_nettype none

module rv32e_mem_arb
  import rv32e_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic       cmd_id;
  logic [2:0] wait_cnt;
  logic       win_id;
  logic       win_valid;
  logic       arb;

  assign arb = (state == ST_IDLE);

  rv32e_arb_sel #(
    .MAX_STREAK(MAX_STREAK)
  ) u_sel (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .d_req     (d_req),
    .arb       (arb),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // The mem_* command registers are loaded on the IDLE win so gnt and mem_req
  // appear together in the ISSUE cycle without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_id    <= REQ_IF;
      wait_cnt  <= 3'd0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_req   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            cmd_id  <= win_id;
            mem_req <= 1'b1;
            state   <= ST_ISSUE;
            if (win_id == REQ_D) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= (MEM_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (cmd_id == REQ_IF) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= mem_we ? '0 : mem_rdata;
            d_rvalid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32e_mem_arb.sv
// tb_rv32e_mem_arb: directed checks of rv32e_mem_arb at MEM_LATENCY 1 and 3.
// Revision: 1.0
`default_nettype none

module tb_rv32e_mem_arb;
  import rv32e_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance with MEM_LATENCY = 1
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  rv32e_mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ~a;
  endfunction

  // One-cycle memory: data for a command appears in the cycle after mem_req.
  always @(posedge clk) if (mem_req) mem_rdata <= mem_fn(mem_addr);

  // Requesters must hold req and addr stable until their gnt.
  logic        p_ifreq = 1'b0, p_ifgnt = 1'b0, p_dreq = 1'b0, p_dgnt = 1'b0;
  logic [31:0] p_ifaddr = '0, p_daddr = '0;
  always @(posedge clk) begin
    if (rst_n && p_ifreq && !p_ifgnt && !if_gnt)
      assert (if_req && if_addr == p_ifaddr) else $error("protocol: if_req/if_addr changed before if_gnt");
    if (rst_n && p_dreq && !p_dgnt && !d_gnt)
      assert (d_req && d_addr == p_daddr) else $error("protocol: d_req/d_addr changed before d_gnt");
    p_ifreq <= if_req; p_ifgnt <= if_gnt; p_ifaddr <= if_addr;
    p_dreq  <= d_req;  p_dgnt  <= d_gnt;  p_daddr  <= d_addr;
  end

  // Instance with MEM_LATENCY = 3, memory data driven directly by the bench
  logic        rst3 = 1'b0;
  logic        if_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
  logic [31:0] if_addr3 = '0, d_addr3 = '0, d_wdata3 = '0;
  logic [3:0]  d_wstrb3 = '0;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_req3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_wstrb3;
  logic [31:0] mem_rdata3 = 32'h11111111;

  rv32e_mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .reset(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_wstrb(d_wstrb3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata3)
  );

  int   n;
  logic done_if, done_d, seen;

  initial begin
    repeat (3) tick();
    chk("rst_state", dut.state, ST_IDLE);
    chk("rst_streak", dut.u_sel.streak, 0);
    chk("rst_ctl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_wstrb}, 0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    rst3  = 1'b1;

    // Fetch only: req at cycle 0
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("fetch_gnt", {if_gnt, d_gnt, mem_req}, 3'b101);
    chk("fetch_addr", mem_addr, 32'h10);
    chk("fetch_we_strb", {mem_we, mem_wstrb}, 0);
    if_req = 1'b0;
    tick();
    chk("fetch_c2", {if_rvalid, mem_req}, 0);
    tick();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

    // Store: req at this IDLE cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    tick();
    chk("store_gnt", {if_gnt, d_gnt, mem_req, mem_we}, 4'b0111);
    chk("store_addr", mem_addr, 32'h20);
    chk("store_wdata", mem_wdata, 32'h12345678);
    chk("store_strb", mem_wstrb, 4'b0011);
    d_req = 1'b0;
    tick();
    chk("store_c2", {d_rvalid, mem_req}, 0);
    tick();
    chk("store_rvalid", d_rvalid, 1);
    chk("store_rdata", d_rdata, 0);

    // Contention: both held; expect D,D,D,D,IF repeating, gnt every 3 cycles
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'hF;
    n = 0; done_if = 1'b0; done_d = 1'b0;
    for (int c = 1; c <= 60 && !(done_if && done_d); c++) begin
      tick();
      chk("cont_one_gnt", if_gnt & d_gnt, 0);
      if (if_gnt | d_gnt) begin
        if (n < 10) begin
          chk("cont_who", if_gnt, (n % 5 == 4));
          chk("cont_cyc", c, 1 + 3 * n);
          if (if_gnt) chk("cont_if_we_strb", {mem_we, mem_wstrb}, 0);
        end
        n++;
        if (n >= 10) begin
          if (if_gnt) begin if_req = 1'b0; done_if = 1'b1; end
          if (d_gnt)  begin d_req  = 1'b0; done_d  = 1'b1; end
        end
      end
    end
    chk("cont_n", n, 11);
    repeat (4) tick();

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_req", mem_req, 0);
      chk("idle_state", dut.state, ST_IDLE);
    end

    // Latency 3: only the value present at cycle 4 is returned
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h40;
    tick();
    chk("lat_gnt", {d_gnt3, mem_req3, mem_we3}, 3'b110);
    chk("lat_addr", mem_addr3, 32'h40);
    d_req3 = 1'b0;
    tick();
    chk("lat_c2", d_rvalid3, 0);
    tick();
    chk("lat_c3", d_rvalid3, 0);
    tick();
    mem_rdata3 = 32'hCAFEF00D;
    chk("lat_c4", d_rvalid3, 0);
    tick();
    mem_rdata3 = 32'h22222222;
    chk("lat_rvalid", d_rvalid3, 1);
    chk("lat_rdata", d_rdata3, 32'hCAFEF00D);
    tick();
    chk("lat_c6", d_rvalid3, 0);

    // Reset in the WAIT cycle after gnt abandons the transaction
    if_req3 = 1'b1; if_addr3 = 32'h50;
    d_req3 = 1'b1; d_addr3 = 32'h60;
    tick();
    chk("rstm_gnt", {if_gnt3, d_gnt3}, 2'b01);
    chk("rstm_streak1", dut3.u_sel.streak, 1);
    d_req3 = 1'b0;
    tick();
    chk("rstm_wait", dut3.state, ST_WAIT);
    rst3 = 1'b0; if_req3 = 1'b0;
    tick();
    chk("rstm_state", dut3.state, ST_IDLE);
    chk("rstm_streak", dut3.u_sel.streak, 0);
    chk("rstm_ctl", {if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_req3, mem_we3, mem_wstrb3}, 0);
    chk("rstm_addr_wdata", {mem_addr3, mem_wdata3}, 0);
    chk("rstm_rdata", {if_rdata3, d_rdata3}, 0);
    rst3 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_rdata3 = 32'h33333333 + 32'(c);
      tick();
      seen = seen | d_rvalid3 | mem_req3;
    end
    chk("rstm_no_rvalid", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
